// File: rtl/fg_pe_array.sv
// fg_pe_array: P-lane two-stage min-sum f/g processing-element array with symmetric saturation and valid/ready flow control
module fg_pe_array #(
  parameter int LLR_W = 12,
  parameter int P     = 4,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_f,
  input  logic [P*LLR_W-1:0] in_a,
  input  logic [P*LLR_W-1:0] in_b,
  input  logic [P-1:0]       in_s,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P*LLR_W-1:0] out_llr,
  output logic [P-1:0]       out_sat,
  output logic [TAG_W-1:0]   out_tag,
  input  logic               clr_stats,
  output logic [CNT_W-1:0]   sat_cnt
);
  localparam int M = LLR_W - 1;
  localparam int SW = LLR_W + 1;
  localparam logic signed [SW-1:0] MAX_X = {2'b00, {M{1'b1}}};
  localparam logic signed [SW-1:0] MIN_X = -MAX_X;
  logic advance, v1, f1;
  logic [TAG_W-1:0] tag1;
  logic [P*M-1:0] abs_a0, abs_b0, abs_a1, abs_b1;
  logic [P-1:0] amin0, amin1, sgn0, sgn1, sat_n;
  logic [P*SW-1:0] sum0, sum1;
  logic [P*LLR_W-1:0] llr_n;
  assign advance = !out_valid || out_ready;
  assign in_ready = advance;
  for (genvar i = 0; i < P; i++) begin : g_lane
    logic signed [LLR_W-1:0] a, b, na, nb;
    logic signed [SW-1:0] sum;
    logic [M-1:0] ma, mb, mag;
    logic [LLR_W-1:0] fr;
    logic a_min, b_min, hi, lo;
    assign a = in_a[i*LLR_W +: LLR_W];
    assign b = in_b[i*LLR_W +: LLR_W];
    assign na = -a;
    assign nb = -b;
    // the most negative code has no positive twin, so its magnitude pins to MAX
    assign a_min = a[M] && (a[M-1:0] == '0);
    assign b_min = b[M] && (b[M-1:0] == '0);
    assign abs_a0[i*M +: M] = a_min ? '1 : (a[M] ? na[M-1:0] : a[M-1:0]);
    assign abs_b0[i*M +: M] = b_min ? '1 : (b[M] ? nb[M-1:0] : b[M-1:0]);
    assign amin0[i] = a_min || b_min;
    assign sgn0[i] = a[M] ^ b[M];
    assign sum0[i*SW +: SW] = in_s[i] ? {b[M], b} - {a[M], a} : {b[M], b} + {a[M], a};
    assign ma = abs_a1[i*M +: M];
    assign mb = abs_b1[i*M +: M];
    assign mag = ma < mb ? ma : mb;
    assign fr = sgn1[i] ? -{1'b0, mag} : {1'b0, mag};
    assign sum = sum1[i*SW +: SW];
    assign hi = sum > MAX_X;
    assign lo = sum < MIN_X;
    assign llr_n[i*LLR_W +: LLR_W] = f1 ? fr : hi ? MAX_X[M:0] : lo ? MIN_X[M:0] : sum[M:0];
    assign sat_n[i] = f1 ? amin1[i] : hi || lo;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      f1 <= 1'b0;
      tag1 <= '0;
      abs_a1 <= '0;
      abs_b1 <= '0;
      amin1 <= '0;
      sgn1 <= '0;
      sum1 <= '0;
      out_valid <= 1'b0;
      out_llr <= '0;
      out_sat <= '0;
      out_tag <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      f1 <= in_f;
      tag1 <= in_tag;
      abs_a1 <= abs_a0;
      abs_b1 <= abs_b0;
      amin1 <= amin0;
      sgn1 <= sgn0;
      sum1 <= sum0;
      out_valid <= v1;
      out_llr <= llr_n;
      out_sat <= sat_n;
      out_tag <= tag1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clr_stats) sat_cnt <= '0;
    else if (out_valid && out_ready && |out_sat && !(&sat_cnt)) sat_cnt <= sat_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_fg_pe_array.sv
// tb_fg_pe_array: table vectors, hand-written corner sequences and a scoreboard against a golden lane model
module tb_fg_pe_array;
  localparam int W = 12;
  localparam int P = 4;
  localparam int TW = 8;
  typedef struct {
    bit f;
    int a[P];
    int b[P];
    bit [P-1:0] s;
    int e[P];
    bit [P-1:0] esat;
  } vec_t;
  typedef struct packed {
    logic [P*W-1:0] llr;
    logic [P-1:0] sat;
    logic [TW-1:0] tag;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, in_f = 0, out_ready = 1, clr_stats = 0;
  logic [P*W-1:0] in_a = '0, in_b = '0;
  logic [P-1:0] in_s = '0;
  logic [TW-1:0] in_tag = '0;
  logic in_ready, out_valid, in_ready2, out_valid2;
  logic [P*W-1:0] out_llr, out_llr2;
  logic [P-1:0] out_sat, out_sat2;
  logic [TW-1:0] out_tag, out_tag2;
  logic [15:0] sat_cnt;
  logic [1:0] sat_cnt2;
  int tests = 0, fails = 0, n_out = 0, exp_cnt = 0, exp_cnt2 = 0;
  bit done = 0;
  exp_t q[$];
  vec_t tbl[4];
  fg_pe_array #(.LLR_W(W), .P(P), .TAG_W(TW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_f(in_f),
    .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_llr(out_llr), .out_sat(out_sat), .out_tag(out_tag),
    .clr_stats(clr_stats), .sat_cnt(sat_cnt));
  fg_pe_array #(.LLR_W(W), .P(P), .TAG_W(TW), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_f(in_f),
    .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_tag(in_tag), .out_valid(out_valid2),
    .out_ready(out_ready), .out_llr(out_llr2), .out_sat(out_sat2), .out_tag(out_tag2),
    .clr_stats(clr_stats), .sat_cnt(sat_cnt2));
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic exp_t model(logic f, logic [P*W-1:0] a, logic [P*W-1:0] b, logic [P-1:0] s, logic [TW-1:0] tag);
    exp_t r;
    r.tag = tag;
    for (int i = 0; i < P; i++) begin
      logic signed [W-1:0] ta, tb;
      int x, y, v, ax, ay;
      logic st;
      ta = a[i*W +: W];
      tb = b[i*W +: W];
      x = ta;
      y = tb;
      if (f) begin
        ax = (x == -2048) ? 2047 : (x < 0 ? -x : x);
        ay = (y == -2048) ? 2047 : (y < 0 ? -y : y);
        v = ax < ay ? ax : ay;
        if ((x < 0) != (y < 0)) v = -v;
        st = (x == -2048) || (y == -2048);
      end else begin
        v = s[i] ? y - x : y + x;
        st = (v > 2047) || (v < -2047);
        if (v > 2047) v = 2047;
        if (v < -2047) v = -2047;
      end
      r.llr[i*W +: W] = v[W-1:0];
      r.sat[i] = st;
    end
    return r;
  endfunction
  function automatic logic [P*W-1:0] pk(int v[P]);
    logic [P*W-1:0] r;
    for (int i = 0; i < P; i++) r[i*W +: W] = W'(v[i]);
    return r;
  endfunction
  function automatic logic [P*W-1:0] rl();
    logic [P*W-1:0] r;
    for (int i = 0; i < P; i++) begin
      int sel;
      sel = $urandom_range(0, 4);
      r[i*W +: W] = sel == 0 ? 12'h800 : sel == 1 ? 12'h7ff : W'($urandom());
    end
    return r;
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send(logic f, logic [P*W-1:0] a, logic [P*W-1:0] b, logic [P-1:0] s, logic [TW-1:0] tag);
    int n = 0;
    in_valid = 1; in_f = f; in_a = a; in_b = b; in_s = s; in_tag = tag;
    @(negedge clk);
    while (!in_ready && n < 200) begin n++; @(negedge clk); end
    if (!in_ready) begin tests++; fails++; $display("FAIL send_timeout: in_ready got 0 expected 1"); end
    @(posedge clk); #1 in_valid = 0;
  endtask
  task automatic send_vec(int k, logic [TW-1:0] tag);
    send(tbl[k].f, pk(tbl[k].a), pk(tbl[k].b), tbl[k].s, tag);
  endtask
  task automatic idle(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic drain(string nm);
    for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
    chk(nm, 64'(q.size()), 0);
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    logic hit;
    exp_t e;
    hit = 1'b0;
    chk("sat_cnt", 64'(sat_cnt), 64'(exp_cnt));
    chk("sat_cnt_w2", 64'(sat_cnt2), 64'(exp_cnt2));
    if (rst) begin
      q.delete();
      exp_cnt = 0;
      exp_cnt2 = 0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got tag %0h with empty scoreboard", out_tag);
        end else begin
          e = q.pop_front();
          hit = |e.sat;
          n_out++;
          chk("beat", 64'({out_llr, out_sat, out_tag}), 64'(e));
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_f, in_a, in_b, in_s, in_tag));
      if (clr_stats) begin
        exp_cnt = 0;
        exp_cnt2 = 0;
      end else if (hit) begin
        if (exp_cnt < 65535) exp_cnt++;
        if (exp_cnt2 < 3) exp_cnt2++;
      end
    end
  end
  initial begin
    int n0;
    tbl[0] = '{1'b1, '{-100, -2048, -2048, 0}, '{37, 5, -2048, -9}, 4'b0000, '{-37, -5, 2047, 0}, 4'b0110};
    tbl[1] = '{1'b0, '{2000, -2048, -1500, 300}, '{100, 0, -1000, -200}, 4'b1010, '{2047, 2047, -2047, -500}, 4'b0111};
    tbl[2] = '{1'b1, '{5, -7, 2047, -2047}, '{9, -3, -2047, 2047}, 4'b1111, '{5, 3, -2047, -2047}, 4'b0000};
    tbl[3] = '{1'b0, '{1, 2, -3, 0}, '{1, 2, 3, 0}, 4'b0101, '{0, 4, 6, 0}, 4'b0000};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_llr", 64'(out_llr), 0);
    chk("rst_out_sat", 64'(out_sat), 0);
    chk("rst_out_tag", 64'(out_tag), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      send_vec(k, TW'(k + 16));
      @(negedge clk);
      chk("lat_cycle1_valid", 64'(out_valid), 0);
      @(negedge clk);
      chk("lat_cycle2_valid", 64'(out_valid), 1);
      chk("tbl_llr", 64'(out_llr), 64'(pk(tbl[k].e)));
      chk("tbl_sat", 64'(out_sat), 64'(tbl[k].esat));
      chk("tbl_tag", 64'(out_tag), 64'(k + 16));
      @(posedge clk); #1;
    end
    n0 = n_out;
    fork
      for (int k = 0; k < 10; k++) send(k[0] == 0, rl(), rl(), P'($urandom()), TW'(k));
      begin
        logic [P*W-1:0] snap_llr;
        logic [P-1:0] snap_sat;
        for (int n = 0; n < 100 && !(out_valid && out_tag == 3); n++) @(negedge clk);
        chk("stall_find_tag3", 64'(out_tag), 3);
        @(posedge clk); #1 out_ready = 0;
        @(negedge clk);
        snap_llr = out_llr;
        snap_sat = out_sat;
        chk("stall_tag", 64'(out_tag), 4);
        chk("stall_in_ready", 64'(in_ready), 0);
        repeat (2) begin
          @(negedge clk);
          chk("stall_valid", 64'(out_valid), 1);
          chk("stall_llr", 64'(out_llr), 64'(snap_llr));
          chk("stall_sat", 64'(out_sat), 64'(snap_sat));
          chk("stall_tag", 64'(out_tag), 4);
          chk("stall_in_ready", 64'(in_ready), 0);
        end
        @(posedge clk); #1 out_ready = 1;
      end
    join
    drain("stream_drain");
    chk("stream_count", 64'(n_out - n0), 10);
    rst = 1; @(posedge clk); #1 rst = 0;
    for (int k = 0; k < 3; k++) send_vec(0, TW'(k));
    idle(3);
    @(negedge clk);
    chk("stats_three", 64'(sat_cnt), 3);
    chk("stats_three_w2", 64'(sat_cnt2), 3);
    @(posedge clk); #1;
    send_vec(1, 8'h44);
    @(posedge clk); #1 clr_stats = 1;
    @(posedge clk); #1 clr_stats = 0;
    @(negedge clk);
    chk("stats_clr_wins", 64'(sat_cnt), 0);
    chk("stats_clr_wins_w2", 64'(sat_cnt2), 0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) send_vec(k[0], TW'(k + 8'h50));
    idle(3);
    @(negedge clk);
    chk("stats_five", 64'(sat_cnt), 5);
    chk("stats_sticky_w2", 64'(sat_cnt2), 3);
    @(posedge clk); #1;
    send_vec(0, 8'h61);
    send_vec(1, 8'h62);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midrst_valid", 64'(out_valid), 0);
    chk("midrst_sat_cnt", 64'(sat_cnt), 0);
    chk("midrst_in_ready", 64'(in_ready), 1);
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_stale", 64'(out_valid), 0);
    end
    @(posedge clk); #1;
    n0 = n_out;
    fork
      begin
        for (int k = 0; k < 10000; k++)
          if ($urandom_range(0, 3) != 0) send(1'($urandom()), rl(), rl(), P'($urandom()), TW'(k));
          else idle(1);
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = $urandom_range(0, 3) != 0;
          clr_stats = $urandom_range(0, 63) == 0;
          @(posedge clk); #1;
        end
        out_ready = 1;
        clr_stats = 0;
      end
    join
    drain("random_drain");
    chk("random_some_out", 64'(n_out - n0 > 5000), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
